fdtd_pe_stream: RTL and testbench

Parametrised FDTD processing element holding one radial row of Z_SIZE field nodes in local simple-dual-port RAM. It runs ITER sweeps on command. Each sweep streams 3-point axial stencil taps (plus neighbour-PE values) to an external update unit, writes the returned results back in place, then applies a selectable boundary condition. It succeeds the fixed 27-bit/110-node PE with these changes:
- generic width and depth;
- any compute-unit latency via a valid handshake;
- selectable boundary mode;
- per-iteration progress outputs.

---
 rtl/fdtd_pkg.sv | 15 +
 rtl/fdtd_ram_sdp.sv | 37 +++
 rtl/fdtd_pe_stream.sv | 223 ++++++++++++++++++++++
 tb/tb_fdtd_pe_stream.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdtd_pkg.sv
// Shared types and constants for the FDTD row processing element.
package fdtd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WB    = 3'd2,
        BND   = 3'd3,
        SWEND = 3'd4
    } state_t;

    localparam logic BC_MIRROR = 1'b0;
    localparam logic BC_FIXED  = 1'b1;

endpackage

// File: rtl/fdtd_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old word.
module fdtd_ram_sdp #(
    parameter int DATA_W = 27,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 110
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Only the output register is reset; stored contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fdtd_pe_stream.sv
// FDTD processing element: streams 3-point axial taps of one row to an external
// update unit, writes results back in place, then applies the boundary condition.
module fdtd_pe_stream
    import fdtd_pkg::*;
#(
    parameter int DATA_W = 27,
    parameter int ADDR_W = 7,
    parameter int Z_SIZE = 110,
    parameter int ID_W   = 6,
    parameter int ITER_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   pe_id,
    input  logic [ID_W-1:0]   host_sel,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_we,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              start,
    input  logic [ITER_W-1:0] iter_count,
    input  logic              bc_mode,
    output logic [DATA_W-1:0] tap_left,
    output logic [DATA_W-1:0] tap_center,
    output logic [DATA_W-1:0] tap_right,
    output logic              tap_valid,
    output logic [ADDR_W-1:0] tap_addr,
    input  logic [DATA_W-1:0] cu_result,
    input  logic              cu_valid,
    output logic [DATA_W-1:0] nb_value,
    output logic              busy,
    output logic              sweep_done,
    output logic [ITER_W-1:0] iter_done,
    output logic              done,
    output logic [2:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] A_ZERO = '0;
    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TWO  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_PEN  = ADDR_W'(Z_SIZE - 2);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(Z_SIZE - 1);

    // Handshake: cu_valid qualifies cu_result for one cycle; there is no
    // backpressure, results must arrive in tap order, one per cycle at most.

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_rdata_addr;
    logic              r_rdata_vld;
    logic [ADDR_W-1:0] r_wp;
    logic [ADDR_W-1:0] r_rcv;
    logic [DATA_W-1:0] r_s1;
    logic [DATA_W-1:0] r_s2;
    logic              r_cu_vld;
    logic [DATA_W-1:0] r_cu_data;
    logic [DATA_W-1:0] r_new_first;
    logic [DATA_W-1:0] r_new_last;
    logic              r_bc;
    logic              r_bnd_cnt;
    logic              r_zero_done;
    logic [ITER_W-1:0] r_iter_tgt;
    logic [ITER_W-1:0] r_iter_done;

    logic              w_busy;
    logic              w_sweep_done;
    logic              w_done;
    logic              w_last_sweep;
    logic              w_start_run;
    logic              w_start_zero;
    logic              w_cu_take;
    logic              w_bnd_we;
    logic [ADDR_W-1:0] w_bnd_addr;
    logic [DATA_W-1:0] w_bnd_data;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_waddr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [ADDR_W-1:0] w_ram_raddr;
    logic [DATA_W-1:0] w_ram_rdata;
    logic              w_host_act;

    assign w_start_run  = (r_state == IDLE) && start && (iter_count != '0);
    assign w_start_zero = (r_state == IDLE) && start && (iter_count == '0);
    assign w_last_sweep = (r_iter_done == r_iter_tgt);
    assign w_cu_take    = cu_valid && ((r_state == READ) || (r_state == WB)) && (r_rcv != A_PEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_run) w_next = READ;
            READ:    if (r_rd_ptr == A_LAST) w_next = WB;
            WB:      if (r_wp == A_LAST) w_next = (r_bc == BC_FIXED) ? SWEND : BND;
            BND:     if (r_bnd_cnt) w_next = SWEND;
            SWEND:   w_next = w_last_sweep ? IDLE : READ;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy       = (r_state != IDLE);
        w_sweep_done = (r_state == SWEND);
        w_done       = r_zero_done || ((r_state == SWEND) && w_last_sweep);
        w_bnd_we     = (r_state == BND);
        w_bnd_addr   = r_bnd_cnt ? A_LAST : A_ZERO;
        w_bnd_data   = r_bnd_cnt ? r_new_last : r_new_first;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_rdata_addr <= '0;
            r_rdata_vld  <= 1'b0;
            r_wp         <= A_ONE;
            r_rcv        <= '0;
            r_s1         <= '0;
            r_s2         <= '0;
            r_cu_vld     <= 1'b0;
            r_cu_data    <= '0;
            r_new_first  <= '0;
            r_new_last   <= '0;
            r_bc         <= BC_MIRROR;
            r_bnd_cnt    <= 1'b0;
            r_zero_done  <= 1'b0;
            r_iter_tgt   <= '0;
            r_iter_done  <= '0;
        end else begin
            r_zero_done  <= w_start_zero;
            r_rdata_vld  <= (r_state == READ);
            r_rdata_addr <= r_rd_ptr;
            r_bnd_cnt    <= (r_state == BND) ? ~r_bnd_cnt : 1'b0;
            r_cu_vld     <= w_cu_take;

            if (w_start_run) begin
                r_iter_tgt  <= iter_count;
                r_bc        <= bc_mode;
                r_iter_done <= '0;
                r_rd_ptr    <= '0;
            end
            if (r_state == READ) begin
                r_rd_ptr <= (r_rd_ptr == A_LAST) ? A_ZERO : r_rd_ptr + A_ONE;
            end
            // right tap is the RAM output itself; center and left are its history
            if (r_rdata_vld) begin
                r_s1 <= w_ram_rdata;
                r_s2 <= r_s1;
            end
            if (w_cu_take) begin
                r_cu_data <= cu_result;
                r_rcv     <= r_rcv + A_ONE;
            end
            // Edge-adjacent results are kept for the mirror boundary writes.
            if (r_cu_vld) begin
                r_wp <= r_wp + A_ONE;
                if (r_wp == A_ONE) r_new_first <= r_cu_data;
                if (r_wp == A_PEN) r_new_last <= r_cu_data;
            end
            if ((r_state != SWEND) && (w_next == SWEND)) begin
                r_iter_done <= r_iter_done + 1'b1;
            end
            if (r_state == SWEND) begin
                r_wp  <= A_ONE;
                r_rcv <= '0;
            end
        end
    end

    assign w_host_act  = !w_busy && (host_sel == pe_id);
    assign w_ram_raddr = w_busy ? r_rd_ptr : host_addr;

    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = host_addr;
        w_ram_wdata = host_wdata;
        if (w_bnd_we) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = w_bnd_addr;
            w_ram_wdata = w_bnd_data;
        end else if (r_cu_vld) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = r_wp;
            w_ram_wdata = r_cu_data;
        end else begin
            w_ram_we    = host_we && w_host_act;
        end
    end

    fdtd_ram_sdp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (Z_SIZE)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    assign tap_valid  = r_rdata_vld && (r_rdata_addr >= A_TWO);
    assign tap_addr   = tap_valid ? (r_rdata_addr - A_ONE) : A_ZERO;
    assign tap_right  = w_ram_rdata;
    assign tap_center = r_s1;
    assign tap_left   = r_s2;
    assign nb_value   = r_s1;
    assign host_rdata = w_ram_rdata;
    assign busy       = w_busy;
    assign sweep_done = w_sweep_done;
    assign done       = w_done;
    assign iter_done  = r_iter_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_fdtd_pe_stream.sv
// Directed bench for fdtd_pe_stream on an 8-node row with a delay-line update unit
// that returns left+right after a programmable number of cycles.
module tb_fdtd_pe_stream;

    localparam int DATA_W = 27;
    localparam int ADDR_W = 7;
    localparam int Z_SIZE = 8;
    localparam int ID_W   = 6;
    localparam int ITER_W = 16;
    localparam logic [ID_W-1:0] MY_ID  = 6'd5;
    localparam logic [2:0]      ST_IDLE = 3'd0;
    localparam logic [2:0]      ST_WB   = 3'd2;

    typedef logic [DATA_W-1:0] row_t [Z_SIZE];

    logic              clk = 1'b0;
    logic              rst;
    logic [ID_W-1:0]   pe_id;
    logic [ID_W-1:0]   host_sel;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_we;
    logic [DATA_W-1:0] host_rdata;
    logic              start;
    logic [ITER_W-1:0] iter_count;
    logic              bc_mode;
    logic [DATA_W-1:0] tap_left, tap_center, tap_right;
    logic              tap_valid;
    logic [ADDR_W-1:0] tap_addr;
    logic [DATA_W-1:0] cu_result;
    logic              cu_valid;
    logic [DATA_W-1:0] nb_value;
    logic              busy, sweep_done, done;
    logic [ITER_W-1:0] iter_done;
    logic [2:0]        dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    int                cu_lat = 1;
    logic              line_v [0:7];
    logic [DATA_W-1:0] line_d [0:7];

    int                sd_cyc[$];
    logic [ITER_W-1:0] sd_iter[$];
    int                done_cyc;

    int exp_ramp[8] = '{0, 10, 20, 30, 40, 50, 60, 70};
    int exp_mir1[8] = '{20, 20, 40, 60, 80, 100, 120, 120};
    int exp_fix1[8] = '{0, 20, 40, 60, 80, 100, 120, 70};
    int exp_mir3[8] = '{140, 140, 180, 240, 320, 380, 420, 420};

    fdtd_pe_stream #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .Z_SIZE (Z_SIZE),
        .ID_W   (ID_W),
        .ITER_W (ITER_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pe_id      (pe_id),
        .host_sel   (host_sel),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_we    (host_we),
        .host_rdata (host_rdata),
        .start      (start),
        .iter_count (iter_count),
        .bc_mode    (bc_mode),
        .tap_left   (tap_left),
        .tap_center (tap_center),
        .tap_right  (tap_right),
        .tap_valid  (tap_valid),
        .tap_addr   (tap_addr),
        .cu_result  (cu_result),
        .cu_valid   (cu_valid),
        .nb_value   (nb_value),
        .busy       (busy),
        .sweep_done (sweep_done),
        .iter_done  (iter_done),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // Update unit: result for a tap appears cu_lat cycles after the tap.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                line_v[i] = 1'b0;
                line_d[i] = '0;
            end
            cu_valid  = 1'b0;
            cu_result = '0;
        end else begin
            for (int i = 7; i > 0; i--) begin
                line_v[i] = line_v[i-1];
                line_d[i] = line_d[i-1];
            end
            line_v[0] = tap_valid;
            line_d[0] = tap_left + tap_right;
            cu_valid  = line_v[cu_lat];
            cu_result = line_d[cu_lat];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic host_write(input logic [ID_W-1:0] sel, input int a, input int d);
        host_sel   = sel;
        host_addr  = ADDR_W'(a);
        host_wdata = DATA_W'(d);
        host_we    = 1'b1;
        @(negedge clk);
        host_we    = 1'b0;
        host_sel   = MY_ID;
    endtask

    task automatic host_read(input int a, output logic [DATA_W-1:0] d);
        host_sel  = MY_ID;
        host_addr = ADDR_W'(a);
        host_we   = 1'b0;
        @(negedge clk);
        d = host_rdata;
    endtask

    task automatic read_all(output row_t r);
        for (int i = 0; i < Z_SIZE; i++) host_read(i, r[i]);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < Z_SIZE; i++) host_write(MY_ID, i, i * 10);
    endtask

    // Runs one command; records the cycle (0 = first READ cycle) of every
    // sweep_done and of done, plus iter_done at each sweep_done.
    task automatic run(input int n, input logic bc, input int lat);
        cu_lat = lat;
        sd_cyc.delete();
        sd_iter.delete();
        done_cyc   = -1;
        iter_count = ITER_W'(n);
        bc_mode    = bc;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (sweep_done) begin
                sd_cyc.push_back(c);
                sd_iter.push_back(iter_done);
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || sweep_done !== 1'b0 || tap_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b done=%b sweep_done=%b tap_valid=%b expected all 0",
                     busy, done, sweep_done, tap_valid);
        end
        n_tests++;
        if (iter_done !== '0 || host_rdata !== '0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_data: iter_done=%0d host_rdata=%0d state=%0d expected 0 0 0",
                     iter_done, host_rdata, dbg_state);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_host();
        row_t got;
        logic [DATA_W-1:0] d;
        load_ramp();
        host_read(5, d);
        n_tests++;
        if (d !== DATA_W'(50)) begin
            n_fail++;
            $display("FAIL host_read5: got %0d expected 50", d);
        end
        read_all(got);
        for (int i = 0; i < Z_SIZE; i++) begin
            n_tests++;
            if (got[i] !== DATA_W'(exp_ramp[i])) begin
                n_fail++;
                $display("FAIL host_load[%0d]: got %0d expected %0d", i, got[i], exp_ramp[i]);
            end
        end
        host_write(6'd7, 3, 999);
        host_read(3, d);
        n_tests++;
        if (d !== DATA_W'(30)) begin
            n_fail++;
            $display("FAIL host_foreign_write: got %0d expected 30", d);
        end
    endtask

    task automatic test_mirror();
        row_t got;
        load_ramp();
        run(1, 1'b0, 3);
        n_tests++;
        if (sd_cyc.size() != 1 || done_cyc != 16) begin
            n_fail++;
            $display("FAIL mirror_timing: sweeps=%0d done_cycle=%0d expected 1 16", sd_cyc.size(), done_cyc);
        end else if (sd_cyc[0] != 16 || sd_iter[0] !== ITER_W'(1)) begin
            n_fail++;
            $display("FAIL mirror_sweep: sweep_done cycle=%0d iter_done=%0d expected 16 1", sd_cyc[0], sd_iter[0]);
        end
        n_tests++;
        if (busy !== 1'b0 || iter_done !== ITER_W'(1)) begin
            n_fail++;
            $display("FAIL mirror_end: busy=%b iter_done=%0d expected 0 1", busy, iter_done);
        end
        read_all(got);
        for (int i = 0; i < Z_SIZE; i++) begin
            n_tests++;
            if (got[i] !== DATA_W'(exp_mir1[i])) begin
                n_fail++;
                $display("FAIL mirror_node[%0d]: got %0d expected %0d", i, got[i], exp_mir1[i]);
            end
        end
    endtask

    task automatic test_fixed();
        row_t got;
        load_ramp();
        run(1, 1'b1, 3);
        n_tests++;
        if (sd_cyc.size() != 1 || done_cyc != 14) begin
            n_fail++;
            $display("FAIL fixed_timing: sweeps=%0d done_cycle=%0d expected 1 14", sd_cyc.size(), done_cyc);
        end
        read_all(got);
        for (int i = 0; i < Z_SIZE; i++) begin
            n_tests++;
            if (got[i] !== DATA_W'(exp_fix1[i])) begin
                n_fail++;
                $display("FAIL fixed_node[%0d]: got %0d expected %0d", i, got[i], exp_fix1[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t got;
        int   lats[2] = '{1, 7};
        int   period[2] = '{0, 0};
        for (int r = 0; r < 2; r++) begin
            load_ramp();
            run(3, 1'b0, lats[r]);
            n_tests++;
            if (sd_cyc.size() != 3 || done_cyc < 0) begin
                n_fail++;
                $display("FAIL b2b_count lat=%0d: sweeps=%0d done_cycle=%0d expected 3 sweeps and done",
                         lats[r], sd_cyc.size(), done_cyc);
            end else begin
                for (int k = 0; k < 3; k++) begin
                    n_tests++;
                    if (sd_iter[k] !== ITER_W'(k + 1)) begin
                        n_fail++;
                        $display("FAIL b2b_iter_done lat=%0d sweep %0d: got %0d expected %0d",
                                 lats[r], k, sd_iter[k], k + 1);
                    end
                end
                period[r] = sd_cyc[1] - sd_cyc[0];
                n_tests++;
                if (period[r] != Z_SIZE + 3 + lats[r] + 2 + 1) begin
                    n_fail++;
                    $display("FAIL b2b_period lat=%0d: got %0d expected %0d",
                             lats[r], period[r], Z_SIZE + 3 + lats[r] + 3);
                end
            end
            read_all(got);
            for (int i = 0; i < Z_SIZE; i++) begin
                n_tests++;
                if (got[i] !== DATA_W'(exp_mir3[i])) begin
                    n_fail++;
                    $display("FAIL b2b_node lat=%0d [%0d]: got %0d expected %0d",
                             lats[r], i, got[i], exp_mir3[i]);
                end
            end
        end
        n_tests++;
        if (period[1] - period[0] != 6) begin
            n_fail++;
            $display("FAIL b2b_period_delta: got %0d expected 6", period[1] - period[0]);
        end
    endtask

    task automatic test_zero_and_ignore();
        row_t got;
        int   n_sd = 0;
        int   d_cyc = -1;
        load_ramp();
        iter_count = '0;
        bc_mode    = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_iter_done: done=%b busy=%b expected 1 0", done, busy);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_iter_after: done=%b busy=%b expected 0 0", done, busy);
        end
        read_all(got);
        for (int i = 0; i < Z_SIZE; i++) begin
            n_tests++;
            if (got[i] !== DATA_W'(exp_ramp[i])) begin
                n_fail++;
                $display("FAIL zero_iter_node[%0d]: got %0d expected %0d", i, got[i], exp_ramp[i]);
            end
        end
        // Second start while busy carries a different count and mode.
        cu_lat     = 2;
        iter_count = ITER_W'(1);
        bc_mode    = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (c == 4) begin
                iter_count = ITER_W'(5);
                bc_mode    = 1'b0;
                start      = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (sweep_done) n_sd++;
            if (done) begin
                d_cyc = c;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (n_sd != 1 || d_cyc < 0 || busy !== 1'b0 || iter_done !== ITER_W'(1)) begin
            n_fail++;
            $display("FAIL start_while_busy: sweeps=%0d done_cycle=%0d busy=%b iter_done=%0d expected 1 >=0 0 1",
                     n_sd, d_cyc, busy, iter_done);
        end
        read_all(got);
        for (int i = 0; i < Z_SIZE; i++) begin
            n_tests++;
            if (got[i] !== DATA_W'(exp_fix1[i])) begin
                n_fail++;
                $display("FAIL start_while_busy_node[%0d]: got %0d expected %0d", i, got[i], exp_fix1[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        row_t got;
        int   waited = 0;
        bit   seen_sd = 1'b0;
        load_ramp();
        cu_lat     = 3;
        iter_count = ITER_W'(2);
        bc_mode    = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(seen_sd && dbg_state == ST_WB) && waited < 200) begin
            if (sweep_done) seen_sd = 1'b1;
            @(negedge clk);
            waited++;
        end
        n_tests++;
        if (waited >= 200) begin
            n_fail++;
            $display("FAIL midrun_reach_wb: state=%0d after %0d cycles, expected WB in second sweep",
                     dbg_state, waited);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || sweep_done !== 1'b0 || iter_done !== '0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL midrun_reset_ctrl: busy=%b done=%b sweep_done=%b iter_done=%0d state=%0d expected 0 0 0 0 0",
                     busy, done, sweep_done, iter_done, dbg_state);
        end
        n_tests++;
        if (tap_valid !== 1'b0 || tap_addr !== '0 || tap_left !== '0 || tap_center !== '0 ||
            tap_right !== '0 || nb_value !== '0 || host_rdata !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset_data: tv=%b ta=%0d tl=%0d tc=%0d tr=%0d nb=%0d hr=%0d expected all 0",
                     tap_valid, tap_addr, tap_left, tap_center, tap_right, nb_value, host_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        load_ramp();
        run(1, 1'b0, 3);
        n_tests++;
        if (sd_cyc.size() != 1 || done_cyc != 16) begin
            n_fail++;
            $display("FAIL midrun_rerun_timing: sweeps=%0d done_cycle=%0d expected 1 16", sd_cyc.size(), done_cyc);
        end
        read_all(got);
        for (int i = 0; i < Z_SIZE; i++) begin
            n_tests++;
            if (got[i] !== DATA_W'(exp_mir1[i])) begin
                n_fail++;
                $display("FAIL midrun_rerun_node[%0d]: got %0d expected %0d", i, got[i], exp_mir1[i]);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        pe_id      = MY_ID;
        host_sel   = MY_ID;
        host_addr  = '0;
        host_wdata = '0;
        host_we    = 1'b0;
        start      = 1'b0;
        iter_count = '0;
        bc_mode    = 1'b0;
        @(negedge clk);
        test_reset();
        test_host();
        test_mirror();
        test_fixed();
        test_back_to_back();
        test_zero_and_ignore();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
